// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: DEPTH-entry instruction queue feeding a registered decoder output.
// Define DECODE_ILLEGAL_EN to enable illegal-instruction detection on out_illegal.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [PC_W-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_W-1:0]              out_pc,
    output logic [31:0]                  out_imm,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [4:0]                   out_rd,
    output logic [3:0]                   out_alu_op,
    output logic [4:0]                   out_opcode,
    output logic [2:0]                   out_funct3,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [4:0] {
        OPC_LOAD   = 5'b00000, OPC_STORE  = 5'b01000, OPC_BRANCH = 5'b11000,
        OPC_JAL    = 5'b11011, OPC_JALR   = 5'b11001, OPC_OP     = 5'b01100,
        OPC_OP_IMM = 5'b00100, OPC_LUI    = 5'b01101, OPC_AUIPC  = 5'b00101,
        OPC_FENCE  = 5'b00011, OPC_SYSTEM = 5'b11100
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
        ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
    } alu_e;

    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, load;

    logic [31:0] head;
    opcode_e     opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] d_imm;
    logic [4:0]  d_rs1, d_rd;
    alu_e        d_alu;
    logic        d_ill;

    assign in_ready = !rst && (count < CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign load     = (count != '0) && (!out_valid || out_ready);

    assign head = instr_mem[rd_ptr];
    assign opc  = opcode_e'(head[6:2]);
    assign f3   = head[14:12];
    assign f7   = head[31:25];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        d_imm = {{20{head[31]}}, head[31:20]};
        d_rs1 = head[19:15];
        d_rd  = 5'd0;
        d_alu = ALU_ADD;
        case (opc)
            OPC_STORE:  d_imm = {{20{head[31]}}, head[31:25], head[11:7]};
            OPC_BRANCH: d_imm = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
            OPC_JAL: begin
                d_imm = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
                d_rd  = head[11:7];
            end
            OPC_LUI: begin
                d_imm = {head[31:12], 12'b0};
                d_rs1 = 5'd0;
                d_rd  = head[11:7];
            end
            OPC_AUIPC: begin
                d_imm = {head[31:12], 12'b0};
                d_rd  = head[11:7];
            end
            OPC_LOAD, OPC_JALR: d_rd = head[11:7];
            OPC_OP, OPC_OP_IMM: begin
                d_rd = head[11:7];
                case (f3)
                    3'b000:  d_alu = (opc == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  d_alu = ALU_SLL;
                    3'b010:  d_alu = ALU_SLT;
                    3'b011:  d_alu = ALU_SLTU;
                    3'b100:  d_alu = ALU_XOR;
                    3'b101:  d_alu = f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  d_alu = ALU_OR;
                    default: d_alu = ALU_AND;
                endcase
            end
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_EN
    always_comb begin
        d_ill = (head[1:0] != 2'b11);
        case (opc)
            OPC_OP:
                if (!(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'b000, 3'b101})))
                    d_ill = 1'b1;
            OPC_OP_IMM:
                if ((f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && !(f7 inside {7'h00, 7'h20})))
                    d_ill = 1'b1;
            OPC_BRANCH: if (f3 inside {3'b010, 3'b011}) d_ill = 1'b1;
            OPC_LOAD:   if (f3 inside {3'b011, 3'b110, 3'b111}) d_ill = 1'b1;
            OPC_STORE:  if (f3 > 3'b010) d_ill = 1'b1;
            OPC_JALR:   if (f3 != 3'b000) d_ill = 1'b1;
            OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_FENCE, OPC_SYSTEM: ;
            default:    d_ill = 1'b1;
        endcase
    end
`else
    assign d_ill = 1'b0;
`endif

    // NOTE: queue storage has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // NOTE: non-blocking assignments keep every register update on the same edge order-independent.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_alu_op  <= '0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                rd_ptr      <= rd_ptr + 1'b1;
                out_valid   <= 1'b1;
                out_pc      <= pc_mem[rd_ptr];
                out_imm     <= d_imm;
                out_rs1     <= d_rs1;
                out_rs2     <= head[24:20];
                out_rd      <= d_ill ? 5'd0 : d_rd;
                out_alu_op  <= d_ill ? ALU_ADD : d_alu;
                out_opcode  <= head[6:2];
                out_funct3  <= f3;
                out_illegal <= d_ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            count <= count + CW'(push) - CW'(load);
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: queue-based reference model plus directed literal checks.
// Honours DECODE_ILLEGAL_EN the same way the design does.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic            in_ready, out_valid, out_illegal;
    logic [31:0]     in_instr = '0, out_imm;
    logic [PC_W-1:0] in_pc = '0, out_pc;
    logic [4:0]      out_rs1, out_rs2, out_rd, out_opcode;
    logic [3:0]      out_alu_op;
    logic [2:0]      out_funct3;
    logic [CW-1:0]   count;

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_alu_op(out_alu_op),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_illegal(out_illegal),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd, opc;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t          mq[$];
    bit              m_valid;
    dec_t            m_dec;
    logic [PC_W-1:0] m_pc;
    bit              known;
    int              n_cmp, n_bad, accepted;

    logic [4:0] ops [11] = '{5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001, 5'b01100,
                             5'b00100, 5'b01101, 5'b00101, 5'b00011, 5'b11100};
    // ALU code by funct3 for the base (non-alternate) operation.
    logic [3:0] alu_by_f3 [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};

    function automatic bit is_illegal(input logic [31:0] w);
        logic [4:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         listed;
        op = w[6:2]; f3 = w[14:12]; f7 = w[31:25];
        listed = 1'b0;
        foreach (ops[k]) if (ops[k] == op) listed = 1'b1;
        if (w[1:0] != 2'b11 || !listed) return 1'b1;
        if (op == 5'b01100) return !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        if (op == 5'b00100 && f3 == 1) return f7 != 0;
        if (op == 5'b00100 && f3 == 5) return !(f7 == 0 || f7 == 7'h20);
        if (op == 5'b11000) return f3 == 2 || f3 == 3;
        if (op == 5'b00000) return f3 == 3 || f3 >= 6;
        if (op == 5'b01000) return f3 > 2;
        if (op == 5'b11001) return f3 != 0;
        return 1'b0;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int   imm;
        logic [4:0] op;
        op = w[6:2];
        if (op == 5'b01000)                     imm = $signed({w[31:25], w[11:7]});
        else if (op == 5'b11000)                imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        else if (op == 5'b11011)                imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        else if (op == 5'b01101 || op == 5'b00101) imm = int'(w & 32'hFFFF_F000);
        else                                    imm = $signed(w[31:20]);
        d.imm = imm;
        d.rs1 = (op == 5'b01101) ? 5'd0 : w[19:15];
        d.rs2 = w[24:20];
        d.rd  = (op inside {5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000})
                ? w[11:7] : 5'd0;
        d.alu = 4'd0;
        if (op == 5'b01100 || op == 5'b00100) begin
            d.alu = alu_by_f3[w[14:12]];
            if (w[14:12] == 3'd0 && op == 5'b01100 && w[30]) d.alu = 4'd1;
            if (w[14:12] == 3'd5 && w[30])                   d.alu = 4'd9;
        end
        d.opc = op;
        d.f3  = w[14:12];
`ifdef DECODE_ILLEGAL_EN
        d.ill = is_illegal(w);
`else
        d.ill = 1'b0;
`endif
        if (d.ill) begin
            d.rd  = 5'd0;
            d.alu = 4'd0;
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_state();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("count", 32'(count), 32'(mq.size()));
        if (m_valid) begin
            check("out_pc", 32'(out_pc), 32'(m_pc));
            check("out_imm", out_imm, m_dec.imm);
            check("out_rs1", 32'(out_rs1), 32'(m_dec.rs1));
            check("out_rs2", 32'(out_rs2), 32'(m_dec.rs2));
            check("out_rd", 32'(out_rd), 32'(m_dec.rd));
            check("out_alu_op", 32'(out_alu_op), 32'(m_dec.alu));
            check("out_opcode", 32'(out_opcode), 32'(m_dec.opc));
            check("out_funct3", 32'(out_funct3), 32'(m_dec.f3));
            check("out_illegal", 32'(out_illegal), 32'(m_dec.ill));
        end
    endtask

    // One clock: compare at the falling edge, drive, then advance model and DUT together.
    task automatic cycle(input bit v, input logic [31:0] w, input logic [PC_W-1:0] pc,
                         input bit ordy, input bit fl, input bit r);
        bit     push, load;
        entry_t e;
        if (known) compare_state();
        in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
        #1;
        check("in_ready", 32'(in_ready), 32'(!r && mq.size() < DEPTH));
        push = v && !r && mq.size() < DEPTH;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_valid = 1'b0;
            m_pc    = '0;
            m_dec   = '{default: '0};
            known   = 1'b1;
        end else if (fl) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            load = mq.size() > 0 && (!m_valid || ordy);
            if (load) begin
                e       = mq.pop_front();
                m_valid = 1'b1;
                m_pc    = e.pc;
                m_dec   = ref_decode(e.instr);
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            if (push) begin
                mq.push_back('{instr: w, pc: pc});
                accepted++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 32'h0, '0, ordy, 1'b0, 1'b0);
    endtask

    // Push one word with a free consumer and wait for it to reach the output register.
    task automatic show(input logic [31:0] w, input logic [PC_W-1:0] pc);
        cycle(1'b1, w, pc, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) w[6:2] = ops[k];
        if ($urandom_range(0, 15) != 0) w[1:0] = 2'b11;
        if (w[6:2] == 5'b01100 || w[6:2] == 5'b00100) begin
            case ($urandom_range(0, 2))
                0:       w[31:25] = 7'h00;
                1:       w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        int k;
        @(negedge clk);
        cycle(1'b1, 32'h0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst out_imm", out_imm, 32'd0);
        check("rst out_pc", 32'(out_pc), 32'd0);
        check("rst out_rd", 32'(out_rd), 32'd0);

        show(32'h0050_0093, 32'h100);
        check("addi valid", 32'(out_valid), 32'd1);
        check("addi imm", out_imm, 32'd5);
        check("addi rd", 32'(out_rd), 32'd1);
        check("addi rs1", 32'(out_rs1), 32'd0);
        check("addi alu", 32'(out_alu_op), 32'd0);
        check("addi illegal", 32'(out_illegal), 32'd0);

        show(32'h4020_81B3, 32'h104);
        check("sub alu", 32'(out_alu_op), 32'd1);
        check("sub rs1", 32'(out_rs1), 32'd1);
        check("sub rs2", 32'(out_rs2), 32'd2);
        check("sub rd", 32'(out_rd), 32'd3);
        show(32'h1234_52B7, 32'h108);
        check("lui imm", out_imm, 32'h1234_5000);
        check("lui rs1", 32'(out_rs1), 32'd0);
        check("lui rd", 32'(out_rd), 32'd5);
        show(32'h0020_A423, 32'h10C);
        check("sw imm", out_imm, 32'd8);
        check("sw rd", 32'(out_rd), 32'd0);
        show(32'hFE00_0EE3, 32'h110);
        check("beq imm", out_imm, 32'hFFFF_FFFC);
        check("beq rd", 32'(out_rd), 32'd0);

        // Fill under backpressure, then drain and confirm order.
        cycle(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
        accepted = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h0000_0013, 32'h2000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        check("fill accepted", 32'(accepted), 32'd5);
        check("fill count", 32'(count), 32'd4);
        check("fill in_ready", 32'(in_ready), 32'd0);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                check("drain pc", 32'(out_pc), 32'h2000 + 32'(4 * k));
                k++;
            end
            idle(1'b1);
        end
        check("drain total", 32'(k), 32'd5);

        // Flush with three queued, one held, and a same-cycle push.
        cycle(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0010_0093, 32'h3000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        check("pre-flush count", 32'(count), 32'd3);
        check("pre-flush valid", 32'(out_valid), 32'd1);
        cycle(1'b1, 32'h0020_0113, 32'h4000, 1'b0, 1'b1, 1'b0);
        check("flush count", 32'(count), 32'd0);
        check("flush valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("post-flush valid", 32'(out_valid), 32'd0);
        end

        show(32'h0000_0000, 32'h500);
`ifdef DECODE_ILLEGAL_EN
        check("zero illegal", 32'(out_illegal), 32'd1);
`else
        check("zero illegal", 32'(out_illegal), 32'd0);
`endif
        check("zero rd", 32'(out_rd), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), PC_W'($urandom),
                  (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
        end
        compare_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
